// File: rtl/add_const_pipe_pkg.sv
// rtl/add_const_pipe_pkg.sv - shared limits, slice-width helper and parameter checks for uncore arithmetic
package add_const_pipe_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Stage count in range and the word splits evenly into slices.
  function automatic bit stages_ok(input int width, input int stages);
    return (width >= 1) && (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
           ((width % stages) == 0);
  endfunction

  // The constant addend must fit in the operand width.
  function automatic bit step_ok(input int width, input longint unsigned step);
    if (width >= 64) return 1'b1;
    return step < (64'd1 << width);
  endfunction

endpackage

// File: rtl/add_const_pipe_if.sv
// rtl/add_const_pipe_if.sv - operand/result valid-ready stream bundle
interface add_const_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/add_const_slice.sv
// rtl/add_const_slice.sv - one pipeline stage: register plus SW-bit add of its slice
module add_const_slice
  import add_const_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_carry,
  input  logic [SW-1:0]    step_slice,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             carry
);

  logic [SW:0]      sum;
  logic [WIDTH-1:0] nxt_data;

  // Add this stage's slice; lower slices are already final, upper ones pass through.
  always_comb begin
    sum      = {1'b0, prev_data[IDX*SW +: SW]} + {1'b0, step_slice} + {{SW{1'b0}}, prev_carry};
    nxt_data = prev_data;
    nxt_data[IDX*SW +: SW] = sum[SW-1:0];
  end

  // Stage register; loading an empty predecessor inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      carry <= 1'b0;
    end else if (load) begin
      valid <= prev_valid;
      data  <= nxt_data;
      carry <= sum[SW];
    end
  end

endmodule

// File: rtl/add_const_pipe.sv
// rtl/add_const_pipe.sv - pipelined add-by-constant, optional clamp under ADD_CONST_PIPE_SAT_EN
module add_const_pipe
  import add_const_pipe_pkg::*;
#(
  parameter int              WIDTH  = 8,
  parameter longint unsigned STEP   = 1,
  parameter int              STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  add_const_pipe_if.slave  bus
);

  localparam int               SW     = slice_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_stages
    $error("add_const_pipe: STAGES must be 1..4 and divide WIDTH");
  end
  if (!step_ok(WIDTH, STEP)) begin : g_bad_step
    $error("add_const_pipe: STEP does not fit in WIDTH bits");
  end

  // Index 0 is the input port, index k+1 is the output of stage k.
  logic             vld [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];
  logic             cry [STAGES+1];
  // rdy[k] is the load enable of stage k; rdy[STAGES] is the consumer.
  logic             rdy [STAGES+1];

  assign vld[0]       = bus.in_valid;
  assign dat[0]       = bus.in_data;
  assign cry[0]       = 1'b0;
  assign rdy[STAGES]  = bus.out_ready;
  assign bus.in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign rdy[k] = !vld[k+1] || rdy[k+1];

    add_const_slice #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (rdy[k]),
      .prev_valid (vld[k]),
      .prev_data  (dat[k]),
      .prev_carry (cry[k]),
      .step_slice (STEP_V[k*SW +: SW]),
      .valid      (vld[k+1]),
      .data       (dat[k+1]),
      .carry      (cry[k+1])
    );
  end

  assign bus.out_valid = vld[STAGES];
  assign bus.out_ovf   = cry[STAGES];

`ifdef ADD_CONST_PIPE_SAT_EN
  assign bus.out_data = cry[STAGES] ? {WIDTH{1'b1}} : dat[STAGES];
`else
  assign bus.out_data = dat[STAGES];
`endif

endmodule
